fmesh_route_stage: RTL and testbench

FMESH_ROUTE_STAGE -- requirements
Module: fmesh_route_stage

---
 rtl/pronoc_pkg.sv | 25 ++
 rtl/fmesh_endp_addr_decode.sv | 29 ++
 rtl/fmesh_route_stage.sv | 167 ++++++++++++++++
 tb/tb_fmesh_route_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pronoc_pkg.sv
// Shared NoC definitions: port numbering, router FSM states and a width helper.
package pronoc_pkg;

  // Router port numbers; LOCAL and anything at or above 5 are endpoint ports.
  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int NORTH = 2;
  localparam int WEST  = 3;
  localparam int SOUTH = 4;

  // Packet tracking state: between packets, or inside a multi-flit packet.
  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } route_state_t;

  // Ceiling log2 with a floor of one bit so that field widths never collapse to zero.
  function automatic int log2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fmesh_endp_addr_decode.sv
// Splits an fmesh endpoint address {ep,ey,ex} into its fields and flags
// coordinates or port numbers that do not exist in this mesh.
module fmesh_endp_addr_decode
  import pronoc_pkg::*;
#(
  parameter  int NX  = 4,
  parameter  int NY  = 4,
  parameter  int NL  = 1,
  parameter  int EAw = 6,
  localparam int P   = 4 + NL,
  localparam int EXw = log2(NX),
  localparam int EYw = log2(NY),
  localparam int EPw = EAw - EXw - EYw
) (
  input  logic [EAw-1:0] e_addr,
  output logic [EXw-1:0] ex,
  output logic [EYw-1:0] ey,
  output logic [EPw-1:0] ep,
  output logic           valid
);

  assign ex = e_addr[EXw-1:0];
  assign ey = e_addr[EXw +: EYw];
  assign ep = e_addr[EXw+EYw +: EPw];

  // Field widths are rounded up, so out-of-range values are representable and must be caught.
  assign valid = (int'(ex) <= NX - 1) && (int'(ey) <= NY - 1) && (int'(ep) <= P - 1);

endmodule

// File: rtl/fmesh_route_stage.sv
// One-entry registered route stage for an fmesh router input: computes the XY
// route on each header, latches it for the rest of the packet, and encodes
// destination-router endpoints on the mesh-edge port numbers.
module fmesh_route_stage
  import pronoc_pkg::*;
#(
  parameter  int NX  = 4,
  parameter  int NY  = 4,
  parameter  int NL  = 1,
  parameter  int EAw = 6,
  parameter  int Fw  = 32,
  localparam int P   = 4 + NL,
  localparam int EXw = log2(NX),
  localparam int EYw = log2(NY),
  localparam int EPw = EAw - EXw - EYw,
  localparam int Pw  = log2(P)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [EXw-1:0] current_x,
  input  logic [EYw-1:0] current_y,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_hdr,
  input  logic           in_tail,
  input  logic [EAw-1:0] in_dest_e_addr,
  input  logic [Fw-1:0]  in_flit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Fw-1:0]  out_flit,
  output logic           out_hdr,
  output logic           out_tail,
  output logic [3:0]     dest_port_coded,
  output logic [Pw-1:0]  endp_localp_num,
  output logic           addr_err
);

  route_state_t   state_q, state_d;
  logic           out_valid_q;
  logic           out_hdr_q;
  logic           out_tail_q;
  logic [Fw-1:0]  out_flit_q;
  logic [3:0]     route_q, route_d;
  logic [Pw-1:0]  localp_q, localp_d;
  logic           addr_err_q;

  logic [EXw-1:0] dst_x;
  logic [EYw-1:0] dst_y;
  logic [EPw-1:0] dst_p;
  logic           dst_ok;
  logic           accept;
  logic           hdr_accept;
  logic           missing_tail;

  fmesh_endp_addr_decode #(
    .NX  (NX),
    .NY  (NY),
    .NL  (NL),
    .EAw (EAw)
  ) u_addr_decode (
    .e_addr (in_dest_e_addr),
    .ex     (dst_x),
    .ey     (dst_y),
    .ep     (dst_p),
    .valid  (dst_ok)
  );

  // The register can take a new flit whenever it is empty or being drained.
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign hdr_accept = accept && in_hdr;

  // XY route for the incoming header; at the destination, edge port numbers map onto the x/y/a/b code.
  always_comb begin
    route_d  = 4'b0000;
    localp_d = '0;
    if (!dst_ok) begin
      route_d  = 4'b0000;
      localp_d = '0;
    end else if (dst_x > current_x) begin
      route_d = 4'b1010;
    end else if (dst_x < current_x) begin
      route_d = 4'b0010;
    end else if (dst_y < current_y) begin
      route_d = 4'b0101;
    end else if (dst_y > current_y) begin
      route_d = 4'b0001;
    end else if (int'(dst_p) == EAST) begin
      route_d = 4'b1010;
    end else if (int'(dst_p) == WEST) begin
      route_d = 4'b0010;
    end else if (int'(dst_p) == NORTH) begin
      route_d = 4'b0101;
    end else if (int'(dst_p) == SOUTH) begin
      route_d = 4'b0001;
    end else begin
      localp_d = Pw'(dst_p);
    end
  end

  // Packet state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Packet state transitions on accepted flits; a header always restarts tracking.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_hdr) begin
        state_d = in_tail ? IDLE : PKT;
      end else if (in_tail) begin
        state_d = IDLE;
      end
    end
  end

  // A header arriving before the previous packet's tail is a protocol error.
  always_comb begin
    missing_tail = hdr_accept && (state_q == PKT);
  end

  // Output pipeline register; the route only reloads on headers so body flits inherit it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_flit_q  <= '0;
      route_q     <= 4'b0000;
      localp_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_hdr_q   <= in_hdr;
      out_tail_q  <= in_tail;
      out_flit_q  <= in_flit;
      if (in_hdr) begin
        route_q  <= route_d;
        localp_q <= localp_d;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky error flag for bad destinations and headers that cut into an open packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
    end else if ((hdr_accept && !dst_ok) || missing_tail) begin
      addr_err_q <= 1'b1;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_hdr         = out_hdr_q;
  assign out_tail        = out_tail_q;
  assign out_flit        = out_flit_q;
  assign dest_port_coded = route_q;
  assign endp_localp_num = localp_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_fmesh_route_stage.sv
// Directed bench for fmesh_route_stage: routing codes, stalls, error flag and reset.
module tb_fmesh_route_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rst_c;
  logic        in_valid;
  logic        in_hdr;
  logic        in_tail;
  logic [6:0]  in_dest;
  logic [31:0] in_flit;
  logic        out_ready;
  logic [1:0]  cx_a, cy_a;

  logic        in_ready_a, out_valid_a, out_hdr_a, out_tail_a, addr_err_a;
  logic [31:0] out_flit_a;
  logic [3:0]  dest_a;
  logic [2:0]  localp_a;

  logic        in_ready_b, out_valid_b, out_hdr_b, out_tail_b, addr_err_b;
  logic [31:0] out_flit_b;
  logic [3:0]  dest_b;
  logic [2:0]  localp_b;

  logic        in_ready_c, out_valid_c, out_hdr_c, out_tail_c, addr_err_c;
  logic [31:0] out_flit_c;
  logic [3:0]  dest_c;
  logic [2:0]  localp_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Main device: 4x4 mesh, one local port, 3-bit ep field so invalid ports are expressible.
  fmesh_route_stage #(.NX(4), .NY(4), .NL(1), .EAw(7), .Fw(32)) dut (
    .clk(clk), .reset(reset), .current_x(cx_a), .current_y(cy_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_hdr(in_hdr), .in_tail(in_tail),
    .in_dest_e_addr(in_dest), .in_flit(in_flit),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_flit(out_flit_a),
    .out_hdr(out_hdr_a), .out_tail(out_tail_a), .dest_port_coded(dest_a),
    .endp_localp_num(localp_a), .addr_err(addr_err_a)
  );

  // Two local ports, router at the (3,0) corner.
  fmesh_route_stage #(.NX(4), .NY(4), .NL(2), .EAw(7), .Fw(32)) dut_nl2 (
    .clk(clk), .reset(reset), .current_x(2'd3), .current_y(2'd0),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_hdr(in_hdr), .in_tail(in_tail),
    .in_dest_e_addr(in_dest), .in_flit(in_flit),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_flit(out_flit_b),
    .out_hdr(out_hdr_b), .out_tail(out_tail_b), .dest_port_coded(dest_b),
    .endp_localp_num(localp_b), .addr_err(addr_err_b)
  );

  // Non-power-of-two row so an out-of-range x coordinate fits in the field.
  fmesh_route_stage #(.NX(3), .NY(4), .NL(1), .EAw(7), .Fw(32)) dut_nx3 (
    .clk(clk), .reset(rst_c), .current_x(2'd0), .current_y(2'd0),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_hdr(in_hdr), .in_tail(in_tail),
    .in_dest_e_addr(in_dest), .in_flit(in_flit),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_flit(out_flit_c),
    .out_hdr(out_hdr_c), .out_tail(out_tail_c), .dest_port_coded(dest_c),
    .endp_localp_num(localp_c), .addr_err(addr_err_c)
  );

  function automatic logic [6:0] ea(input int ep, input int ey, input int ex);
    return {3'(ep), 2'(ey), 2'(ex)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic t,
                       input logic [6:0] d, input logic [31:0] f);
    @(negedge clk);
    in_valid = v;
    in_hdr   = h;
    in_tail  = t;
    in_dest  = d;
    in_flit  = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; rst_c = 1'b0;
    in_valid = 1'b0; in_hdr = 1'b0; in_tail = 1'b0; in_dest = '0; in_flit = '0;
    out_ready = 1'b1; cx_a = 2'd0; cy_a = 2'd0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid_a), 32'd0);
    chk("rst_dest", 32'(dest_a), 32'd0);
    chk("rst_localp", 32'(localp_a), 32'd0);
    chk("rst_addr_err", 32'(addr_err_a), 32'd0);
    chk("rst_flit", out_flit_a, 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    #10 reset = 1'b1;

    // cur (1,1) -> dest (3,1,ep0): east
    cx_a = 2'd1; cy_a = 2'd1;
    drive(1, 1, 1, ea(0, 1, 3), 32'hA1); tick();
    $display("xfer east: dest=%b flit=%h", dest_a, out_flit_a);
    chk("east_valid", 32'(out_valid_a), 32'd1);
    chk("east_dest", 32'(dest_a), 32'b1010);
    chk("east_localp", 32'(localp_a), 32'd0);
    chk("east_hdr", 32'(out_hdr_a), 32'd1);
    chk("east_tail", 32'(out_tail_a), 32'd1);
    chk("east_flit", out_flit_a, 32'hA1);

    // Header flags with in_valid low are ignored
    drive(0, 1, 0, ea(7, 3, 3), 32'hBAD); tick();
    $display("idle: out_valid=%b addr_err=%b", out_valid_a, addr_err_a);
    chk("idle_valid", 32'(out_valid_a), 32'd0);
    chk("idle_err", 32'(addr_err_a), 32'd0);

    // cur (2,2): north, then local ep0
    cx_a = 2'd2; cy_a = 2'd2;
    drive(1, 1, 1, ea(0, 0, 2), 32'hB1); tick();
    $display("xfer north: dest=%b", dest_a);
    chk("north_dest", 32'(dest_a), 32'b0101);
    drive(1, 1, 1, ea(0, 2, 2), 32'hB2); tick();
    $display("xfer local: dest=%b localp=%0d", dest_a, localp_a);
    chk("local_dest", 32'(dest_a), 32'b0000);
    chk("local_localp", 32'(localp_a), 32'd0);
    chk("local_flit", out_flit_a, 32'hB2);
    chk("local_err", 32'(addr_err_a), 32'd0);

    // cur (3,0): edge ports at the destination
    cx_a = 2'd3; cy_a = 2'd0;
    drive(1, 1, 1, ea(1, 0, 3), 32'hC1); tick();
    $display("xfer ep EAST: dest=%b", dest_a);
    chk("ep_east_dest", 32'(dest_a), 32'b1010);
    drive(1, 1, 1, ea(4, 0, 3), 32'hC2); tick();
    $display("xfer ep SOUTH: dest=%b localp=%0d", dest_a, localp_a);
    chk("ep_south_dest", 32'(dest_a), 32'b0001);
    chk("ep_south_localp", 32'(localp_a), 32'd0);
    drive(1, 1, 1, ea(2, 0, 3), 32'hC3); tick();
    $display("xfer ep NORTH: dest=%b", dest_a);
    chk("ep_north_dest", 32'(dest_a), 32'b0101);
    drive(1, 1, 1, ea(3, 0, 3), 32'hC4); tick();
    $display("xfer ep WEST: dest=%b", dest_a);
    chk("ep_west_dest", 32'(dest_a), 32'b0010);

    // 4-flit packet, cur (1,1) -> dest (1,3): south, with a 3-cycle stall
    cx_a = 2'd1; cy_a = 2'd1;
    drive(1, 1, 0, ea(0, 3, 1), 32'hD0); tick();
    $display("pkt f0: dest=%b flit=%h", dest_a, out_flit_a);
    chk("pkt0_dest", 32'(dest_a), 32'b0001);
    chk("pkt0_flit", out_flit_a, 32'hD0);
    chk("pkt0_tail", 32'(out_tail_a), 32'd0);
    drive(1, 0, 0, ea(7, 0, 0), 32'hD1); tick();
    $display("pkt f1: dest=%b flit=%h", dest_a, out_flit_a);
    chk("pkt1_flit", out_flit_a, 32'hD1);
    chk("pkt1_hdr", 32'(out_hdr_a), 32'd0);
    chk("pkt1_dest", 32'(dest_a), 32'b0001);
    out_ready = 1'b0;
    drive(1, 0, 0, ea(0, 0, 0), 32'hD2);
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("stall %0d: in_ready=%b flit=%h", i, in_ready_a, out_flit_a);
      chk("stall_in_ready", 32'(in_ready_a), 32'd0);
      chk("stall_valid", 32'(out_valid_a), 32'd1);
      chk("stall_flit", out_flit_a, 32'hD1);
    end
    out_ready = 1'b1;
    tick();
    $display("pkt f2: dest=%b flit=%h", dest_a, out_flit_a);
    chk("pkt2_flit", out_flit_a, 32'hD2);
    chk("pkt2_dest", 32'(dest_a), 32'b0001);
    drive(1, 0, 1, ea(0, 0, 0), 32'hD3); tick();
    $display("pkt f3: dest=%b flit=%h tail=%b", dest_a, out_flit_a, out_tail_a);
    chk("pkt3_flit", out_flit_a, 32'hD3);
    chk("pkt3_tail", 32'(out_tail_a), 32'd1);
    chk("pkt3_dest", 32'(dest_a), 32'b0001);
    chk("pkt3_err", 32'(addr_err_a), 32'd0);
    drive(0, 0, 0, '0, '0); tick();
    chk("pkt_drained", 32'(out_valid_a), 32'd0);

    // ep5: local port on the NL=2 router, invalid port on the NL=1 router
    drive(1, 1, 1, ea(5, 0, 3), 32'hE0); tick();
    $display("xfer ep5: nl2 dest=%b localp=%0d | nl1 dest=%b err=%b", dest_b, localp_b, dest_a, addr_err_a);
    chk("nl2_dest", 32'(dest_b), 32'b0000);
    chk("nl2_localp", 32'(localp_b), 32'd5);
    chk("nl2_err", 32'(addr_err_b), 32'd0);
    chk("badep_dest", 32'(dest_a), 32'b0000);
    chk("badep_localp", 32'(localp_a), 32'd0);
    chk("badep_err", 32'(addr_err_a), 32'd1);
    drive(0, 0, 0, '0, '0); tick();
    chk("badep_err_sticky", 32'(addr_err_a), 32'd1);

    // Reset in the middle of a packet
    cx_a = 2'd2; cy_a = 2'd2;
    drive(1, 1, 0, ea(0, 2, 3), 32'hF0); tick();
    chk("mid_dest", 32'(dest_a), 32'b1010);
    drive(1, 0, 0, ea(0, 0, 0), 32'hF1); tick();
    chk("mid_flit", out_flit_a, 32'hF1);
    #2 reset = 1'b0;
    #1;
    $display("reset mid-packet: valid=%b dest=%b flit=%h err=%b", out_valid_a, dest_a, out_flit_a, addr_err_a);
    chk("mrst_valid", 32'(out_valid_a), 32'd0);
    chk("mrst_hdr", 32'(out_hdr_a), 32'd0);
    chk("mrst_tail", 32'(out_tail_a), 32'd0);
    chk("mrst_flit", out_flit_a, 32'd0);
    chk("mrst_dest", 32'(dest_a), 32'd0);
    chk("mrst_localp", 32'(localp_a), 32'd0);
    chk("mrst_err", 32'(addr_err_a), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_idle_valid", 32'(out_valid_a), 32'd0);
    // A fresh header must be accepted cleanly: the state was returned to IDLE
    drive(1, 1, 1, ea(0, 2, 0), 32'h10); tick();
    $display("post-reset hdr: dest=%b err=%b", dest_a, addr_err_a);
    chk("postrst_dest", 32'(dest_a), 32'b0010);
    chk("postrst_err", 32'(addr_err_a), 32'd0);

    // Header without a prior tail
    drive(1, 1, 0, ea(0, 2, 3), 32'h20); tick();
    chk("mt_first_dest", 32'(dest_a), 32'b1010);
    chk("mt_first_err", 32'(addr_err_a), 32'd0);
    drive(1, 1, 0, ea(0, 0, 2), 32'h21); tick();
    $display("missing tail: dest=%b err=%b", dest_a, addr_err_a);
    chk("mt_new_dest", 32'(dest_a), 32'b0101);
    chk("mt_err", 32'(addr_err_a), 32'd1);
    drive(1, 0, 1, ea(0, 3, 0), 32'h22); tick();
    chk("mt_tail_dest", 32'(dest_a), 32'b0101);
    chk("mt_tail_err", 32'(addr_err_a), 32'd1);
    drive(1, 1, 1, ea(0, 3, 2), 32'h23); tick();
    chk("mt_next_dest", 32'(dest_a), 32'b0001);
    drive(0, 0, 0, '0, '0); tick();

    // Out-of-range x on the NX=3 router
    rst_c = 1'b1;
    #1;
    chk("nx3_err_init", 32'(addr_err_c), 32'd0);
    drive(1, 1, 1, ea(0, 0, 3), 32'h30); tick();
    $display("xfer bad ex: dest=%b localp=%0d err=%b", dest_c, localp_c, addr_err_c);
    chk("badx_valid", 32'(out_valid_c), 32'd1);
    chk("badx_dest", 32'(dest_c), 32'b0000);
    chk("badx_localp", 32'(localp_c), 32'd0);
    chk("badx_err", 32'(addr_err_c), 32'd1);
    drive(1, 1, 1, ea(0, 0, 1), 32'h31); tick();
    $display("xfer after bad ex: dest=%b err=%b", dest_c, addr_err_c);
    chk("badx_next_dest", 32'(dest_c), 32'b1010);
    chk("badx_err_sticky", 32'(addr_err_c), 32'd1);
    drive(0, 0, 0, '0, '0); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
